// File: rtl/tree_if.sv
// Operand/result bundle for the nine-operand CSA tree.
// Optional TREE_FULL_SUM_EN adds the full-width sum_full result.
interface tree_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h, i;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             out_valid;
`ifdef TREE_FULL_SUM_EN
  logic [WIDTH+3:0] sum_full;

  modport master (
    output in_valid, a, b, c, d, e, f, g, h, i,
    input  s, cout, out_valid, sum_full
  );
  modport slave (
    input  in_valid, a, b, c, d, e, f, g, h, i,
    output s, cout, out_valid, sum_full
  );
`else
  modport master (
    output in_valid, a, b, c, d, e, f, g, h, i,
    input  s, cout, out_valid
  );
  modport slave (
    input  in_valid, a, b, c, d, e, f, g, h, i,
    output s, cout, out_valid
  );
`endif
endinterface

// File: rtl/tree.sv
// Two-stage pipelined Wallace-style CSA tree summing nine unsigned operands.
// Stage 1 registers the four L2 vectors, stage 2 registers the CPA result.
// TREE_FULL_SUM_EN: also drive the untruncated sum on bus.sum_full.
module tree #(
  parameter int unsigned WIDTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  tree_if.slave  bus
);
  // Nine operands of 2^WIDTH-1 fit in WIDTH+4 bits.
  localparam int unsigned W = WIDTH + 4;
  typedef logic [W-1:0] vec_t;

  function automatic vec_t csa_sum(vec_t x, vec_t y, vec_t z);
    return x ^ y ^ z;
  endfunction

  function automatic vec_t csa_carry(vec_t x, vec_t y, vec_t z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  vec_t st1_d [4];
  vec_t st1_q [4];
  logic valid1_d, valid1_q;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;
  vec_t             full_d, full_q;

  // L1 (9->6) and L2 (6->4) reduction feeding stage 1.
  always_comb begin
    vec_t op [9];
    vec_t l1 [6];
    op[0] = {4'b0, bus.a};
    op[1] = {4'b0, bus.b};
    op[2] = {4'b0, bus.c};
    op[3] = {4'b0, bus.d};
    op[4] = {4'b0, bus.e};
    op[5] = {4'b0, bus.f};
    op[6] = {4'b0, bus.g};
    op[7] = {4'b0, bus.h};
    op[8] = {4'b0, bus.i};
    for (int k = 0; k < 3; k++) begin
      l1[2*k]   = csa_sum  (op[3*k], op[3*k+1], op[3*k+2]);
      l1[2*k+1] = csa_carry(op[3*k], op[3*k+1], op[3*k+2]);
    end
    st1_d[0] = csa_sum  (l1[0], l1[1], l1[2]);
    st1_d[1] = csa_carry(l1[0], l1[1], l1[2]);
    st1_d[2] = csa_sum  (l1[3], l1[4], l1[5]);
    st1_d[3] = csa_carry(l1[3], l1[4], l1[5]);
    valid1_d = bus.in_valid;
  end

  // L3 (4->3), L4 (3->2) and the carry-propagate add feeding stage 2.
  always_comb begin
    vec_t l3_s, l3_c, l4_s, l4_c;
    l3_s        = csa_sum  (st1_q[0], st1_q[1], st1_q[2]);
    l3_c        = csa_carry(st1_q[0], st1_q[1], st1_q[2]);
    l4_s        = csa_sum  (l3_s, l3_c, st1_q[3]);
    l4_c        = csa_carry(l3_s, l3_c, st1_q[3]);
    full_d      = l4_s + l4_c;
    s_d         = full_d[WIDTH-1:0];
    cout_d      = |full_d[W-1:WIDTH];
    out_valid_d = valid1_q;
  end

  // Both pipeline stages; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) st1_q[k] <= '0;
      valid1_q    <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      full_q      <= '0;
    end else begin
      for (int k = 0; k < 4; k++) st1_q[k] <= st1_d[k];
      valid1_q    <= valid1_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      full_q      <= full_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = out_valid_q;
`ifdef TREE_FULL_SUM_EN
  assign bus.sum_full  = full_q;
`else
  // Full sum only leaves the block when the wide output is enabled.
  logic unused_full;
  assign unused_full = ^full_q;
`endif
endmodule

// File: tb/tb_tree.sv
// Directed/table-driven bench for the nine-operand CSA tree.
module tb_tree;
  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tree_if #(.WIDTH(WIDTH)) bus ();
  tree #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef logic [8:0][15:0] ops_t;
  typedef struct {
    ops_t        op;
    logic [15:0] s;
    logic        c;
    logic [19:0] full;
  } vec_t;

  int nvec = 0;
  int nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input ops_t op, input logic v);
    bus.a = op[0]; bus.b = op[1]; bus.c = op[2];
    bus.d = op[3]; bus.e = op[4]; bus.f = op[5];
    bus.g = op[6]; bus.h = op[7]; bus.i = op[8];
    bus.in_valid = v;
  endtask

  task automatic check_result(input string name, input logic [15:0] es, input logic ec,
                              input logic [19:0] ef);
    check({name, ".valid"}, {31'b0, bus.out_valid}, 32'd1);
    check({name, ".s"}, {16'b0, bus.s}, {16'b0, es});
    check({name, ".cout"}, {31'b0, bus.cout}, {31'b0, ec});
`ifdef TREE_FULL_SUM_EN
    check({name, ".full"}, {12'b0, bus.sum_full}, {12'b0, ef});
`else
    if (ef == 20'hFFFFF) $display("note: unreachable full sum");
`endif
  endtask

  task automatic check_idle(input string name);
    check({name, ".valid0"}, {31'b0, bus.out_valid}, 32'd0);
  endtask

  function automatic ops_t rand_ops();
    ops_t o;
    for (int k = 0; k < 9; k++) o[k] = 16'($urandom);
    return o;
  endfunction

  function automatic logic [19:0] model(input ops_t o);
    logic [19:0] t = '0;
    for (int k = 0; k < 9; k++) t = t + {4'b0, o[k]};
    return t;
  endfunction

  vec_t tab [8];
  ops_t zero_ops;
  ops_t str_ops [10];
  logic [19:0] str_t [10];

  initial begin
    zero_ops = '0;
    // op[0] is a, op[8] is i
    tab[0].op = {16'd15, 16'd32, 16'd21, 16'd18, 16'd13, 16'd9, 16'd5, 16'd3, 16'd2};
    tab[0].s = 16'd118; tab[0].c = 1'b0; tab[0].full = 20'd118;
    tab[1].op = {9{16'hFFFF}};
    tab[1].s = 16'hFFF7; tab[1].c = 1'b1; tab[1].full = 20'h8FFF7;
    tab[2].op = {128'b0, 16'hFFFF};
    tab[2].s = 16'hFFFF; tab[2].c = 1'b0; tab[2].full = 20'h0FFFF;
    tab[3].op = {112'b0, 16'h0001, 16'hFFFF};
    tab[3].s = 16'h0000; tab[3].c = 1'b1; tab[3].full = 20'h10000;
    tab[4].op = '0;
    tab[4].s = 16'h0000; tab[4].c = 1'b0; tab[4].full = 20'h00000;
    tab[5].op = {9{16'h0001}};
    tab[5].s = 16'h0009; tab[5].c = 1'b0; tab[5].full = 20'h00009;
    tab[6].op = {9{16'h1000}};
    tab[6].s = 16'h9000; tab[6].c = 1'b0; tab[6].full = 20'h09000;
    tab[7].op = {96'b0, 16'h8000, 16'h0000, 16'h8000};
    tab[7].s = 16'h0000; tab[7].c = 1'b1; tab[7].full = 20'h10000;

    // Reset hold with live random inputs.
    drive(rand_ops(), 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_hold.valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_hold.s", {16'b0, bus.s}, 32'd0);
      check("rst_hold.cout", {31'b0, bus.cout}, 32'd0);
      drive(rand_ops(), 1'b1);
    end
    @(negedge clk);
    drive(zero_ops, 1'b0);
    rst_n = 1'b1;

    // Table vectors, one at a time: 2-cycle latency then a bubble.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      drive(tab[v].op, 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(zero_ops, 1'b0);
      @(posedge clk); #1;
      check_result($sformatf("vec%0d", v), tab[v].s, tab[v].c, tab[v].full);
      @(posedge clk); #1;
      check_idle($sformatf("vec%0d.after", v));
    end

    // Streaming 10 back-to-back random sets.
    for (int k = 0; k < 10; k++) begin
      str_ops[k] = rand_ops();
      str_t[k] = model(str_ops[k]);
    end
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k < 10) drive(str_ops[k], 1'b1);
      else drive(zero_ops, 1'b0);
      @(posedge clk); #1;
      if (k == 0) check_idle("stream.pre");
      else check_result($sformatf("stream%0d", k - 1), str_t[k-1][15:0], |str_t[k-1][19:16],
                        str_t[k-1]);
    end
    @(posedge clk); #1;
    check_idle("stream.post");

    // Asynchronous clear of a visible result, no clock edge involved.
    @(negedge clk);
    drive(tab[1].op, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(zero_ops, 1'b0);
    @(posedge clk); #1;
    check_result("async.pre", tab[1].s, tab[1].c, tab[1].full);
    #1 rst_n = 1'b0;
    #1;
    check("async.valid", {31'b0, bus.out_valid}, 32'd0);
    check("async.s", {16'b0, bus.s}, 32'd0);
    check("async.cout", {31'b0, bus.cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream: two sets in flight are discarded.
    @(negedge clk);
    drive(tab[0].op, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(tab[6].op, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    drive(zero_ops, 1'b0);
    #1;
    check_idle("midrst.during");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_idle($sformatf("midrst.flush%0d", k));
    end
    @(negedge clk);
    drive(tab[5].op, 1'b1);
    @(posedge clk); #1;
    check_idle("midrst.lat1");
    @(negedge clk);
    drive(zero_ops, 1'b0);
    @(posedge clk); #1;
    check_result("midrst.new", tab[5].s, tab[5].c, tab[5].full);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/tree.md
Name: tree

Overview:
- Pipelined carry-save adder (CSA) tree that sums nine WIDTH-bit unsigned operands (a..i).
- Carry-save stages reduce the nine operands to two vectors (Wallace style, 3:2 compressors). One carry-propagate adder (CPA) then produces the final sum.
- Used as the multi-operand accumulation stage of the datapath. It delivers the low WIDTH bits of the sum plus a carry-out/overflow flag.

Parameters:
- WIDTH, 16, bit width of each operand and of s.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a..i valid this cycle.
- a  input  WIDTH  operand 0.
- b  input  WIDTH  operand 1.
- c  input  WIDTH  operand 2.
- d  input  WIDTH  operand 3.
- e  input  WIDTH  operand 4.
- f  input  WIDTH  operand 5.
- g  input  WIDTH  operand 6.
- h  input  WIDTH  operand 7.
- i  input  WIDTH  operand 8.
- s  output  WIDTH  registered sum, bits [WIDTH-1:0].
- cout  output  1  registered flag: 1 when the true sum exceeds 2^WIDTH-1.
- out_valid  output  1  s/cout hold a new result.

Behaviour:
- Arithmetic: true sum T = a+b+...+i, all operands unsigned, computed at WIDTH+4 bits (max 9*(2^WIDTH-1) fits).
  - s = T[WIDTH-1:0].
  - cout = |T[WIDTH+3:WIDTH], i.e. an overflow flag, not only bit WIDTH.
- CSA levels, combinational, each vector kept at WIDTH+4 bits with carries shifted left by 1:
  - L1: 9 -> 6 (three CSAs).
  - L2: 6 -> 4 (two CSAs).
  - L3: 4 -> 3.
  - L4: 3 -> 2.
- Pipeline: exactly 2 cycles latency, fully pipelined, one new operand set accepted per cycle, no stall or backpressure.
  - Stage 1 register: captures the four L2 vectors plus valid on the clk edge where the operands are presented.
  - Stage 2 register: captures s, cout and out_valid after L3, L4 and the CPA.
- in_valid=1 at edge N produces out_valid=1 with the matching result after edge N+1, i.e. visible in cycle N+2.
- in_valid=0: the valid bit propagates as 0. Data registers still update; their content is don't-care when out_valid=0.
- Reset, asynchronous on rst_n=0:
  - All pipeline registers, s, cout and out_valid go to 0 immediately.
  - In-flight operations are discarded.
  - Normal operation resumes on the first rising clk edge with rst_n=1.
- Back-to-back inputs produce back-to-back outputs in order, with no bubbles inserted.
- No internal state beyond the two pipeline stages.

Optional Feature:
- Macro TREE_FULL_SUM_EN.
- Defined: adds output port sum_full [WIDTH+3:0], registered in stage 2 alongside s, reset to 0, equal to T.
- Not defined: port absent. s and cout are the only result outputs; behaviour is otherwise identical.

Test Plan:
- Reset hold: rst_n=0 with random operands, in_valid=1 -> s=0, cout=0, out_valid=0 throughout. Asserting rst_n mid-cycle clears outputs without waiting for a clock edge.
- Basic sum: a..i = 2,3,5,9,13,18,21,32,15, in_valid=1 for one cycle -> two cycles later s=118, cout=0, out_valid=1. Next cycle out_valid=0.
- Max overflow: all operands 0xFFFF -> T=0x8FFF7, s=0xFFF7, cout=1 (sum_full=0x8FFF7 when TREE_FULL_SUM_EN).
- Exact boundary: a=0xFFFF, others 0 -> s=0xFFFF, cout=0. Then a=0xFFFF, b=1, others 0 -> s=0x0000, cout=1.
- Streaming: 10 consecutive random operand sets with in_valid=1 -> 10 consecutive out_valid cycles, each matching the reference model T in order, latency 2.
- Reset mid-stream: pulse rst_n low while two results are in flight -> both lost, out_valid stays 0 until new inputs arrive two cycles later.
